// File: rtl/spi_slave_regfile_if.sv
// spi_slave_regfile_if: SPI pins plus local write-commit and frame-done strobes
interface spi_slave_regfile_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              frame_done;

    modport master (output sclk, cs, mosi, input miso, wr_valid, wr_addr, wr_data, frame_done);
    modport slave  (input sclk, cs, mosi, output miso, wr_valid, wr_addr, wr_data, frame_done);
endinterface

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: oversampled SPI mode-0 slave with command-addressed burst access to a local register file
module spi_slave_regfile #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    spi_slave_regfile_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state, state_nxt;
    logic [2:0]        sclk_q, cs_q;
    logic [1:0]        mosi_q;
    logic              rise, fall, cs_rise, cs_fall;
    logic              cmd_done, word_done, rd_fall;
    logic [CW-1:0]     cnt;
    logic [DATA_W-2:0] sh_in;
    logic [DATA_W-1:0] sh_out, word;
    logic              rw;
    logic [ADDR_W-1:0] addr, addr_inc;
    logic [DATA_W-1:0] regs [DEPTH];

    // cs chain resets low so a frame cut by reset is not re-entered until cs is seen high
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            cs_q   <= '0;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sclk};
            cs_q   <= {cs_q[1:0], bus.cs};
            mosi_q <= {mosi_q[0], bus.mosi};
        end
    end

    assign rise     = sclk_q[1] & ~sclk_q[2] & ~cs_q[1];
    assign fall     = ~sclk_q[1] & sclk_q[2] & ~cs_q[1];
    assign cs_rise  = cs_q[1] & ~cs_q[2];
    assign cs_fall  = ~cs_q[1] & cs_q[2];
    assign word     = {sh_in, mosi_q[1]};
    assign addr_inc = addr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise)
            state_nxt = IDLE;
        else if (state == IDLE && cs_fall)
            state_nxt = CMD;
        else if (cmd_done)
            state_nxt = DATA;
    end

    always_comb begin
        cmd_done  = state == CMD && rise && cnt == CW'(7);
        word_done = state == DATA && rise && cnt == CW'(DATA_W - 1);
        rd_fall   = state == DATA && !rw && fall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            sh_in          <= '0;
            sh_out         <= '0;
            rw             <= 1'b0;
            addr           <= '0;
            bus.miso       <= 1'b0;
            bus.wr_valid   <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.frame_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            bus.wr_valid   <= word_done && rw;
            bus.frame_done <= cs_rise && state != IDLE;
            // cs_q[0] is next cycle's synchronized cs, so miso is already low when it goes high
            bus.miso       <= (cs_q[0] || state != DATA || rw) ? 1'b0 : rd_fall ? sh_out[DATA_W-1] : bus.miso;
            if (state == IDLE && cs_fall) begin
                cnt   <= '0;
                sh_in <= '0;
            end else if (rise && state != IDLE) begin
                cnt   <= (cmd_done || word_done) ? '0 : cnt + 1'b1;
                sh_in <= word[DATA_W-2:0];
            end
            if (cmd_done) begin
                rw     <= word[7];
                addr   <= word[ADDR_W-1:0];
                sh_out <= regs[word[ADDR_W-1:0]];
            end
            if (word_done) begin
                addr   <= addr_inc;
                sh_out <= regs[addr_inc];
                if (rw) begin
                    regs[addr]  <= word;
                    bus.wr_addr <= addr;
                    bus.wr_data <= word;
                end
            end
            if (rd_fall)
                sh_out <= {sh_out[DATA_W-2:0], 1'b0};
        end
    end
endmodule

// File: tb/tb_spi_slave_regfile.sv
// tb_spi_slave_regfile: directed and randomized SPI frames checked against an array model of the register file
module tb_spi_slave_regfile;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    spi_slave_regfile #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;
    int fd_cnt = 0;
    logic [DW-1:0]    model [DEPTH];
    logic [AW+DW-1:0] wq[$];
    logic [AW+DW-1:0] exq[$];
    logic [DW-1:0]    wdq[$];
    bit               txq[$];
    logic             rxq[$];

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.wr_valid === 1'b1)
                wq.push_back({bus.wr_addr, bus.wr_data});
            if (bus.frame_done === 1'b1)
                fd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_bits(input logic [DW-1:0] v, input int n);
        for (int i = n - 1; i >= 0; i--)
            txq.push_back(v[i]);
    endtask

    // mode 0: mosi set while sclk low; miso sampled at the end of the high phase
    task automatic frame(input int nbits, input int half);
        rxq.delete();
        bus.cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = txq.size() > 0 ? txq.pop_front() : 1'($urandom);
            repeat (half) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            rxq.push_back(bus.miso);
            bus.sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        bus.cs = 1'b1;
        repeat (6) @(negedge clk);
        txq.delete();
    endtask

    task automatic do_write(input int a, input int n, input int half);
        logic [7:0]    c;
        logic [DW-1:0] w;
        int            f0;
        c = {1'b1, 3'($urandom), 4'(a)};
        push_bits(DW'(c), 8);
        exq.delete();
        wq.delete();
        f0 = fd_cnt;
        for (int k = 0; k < n; k++) begin
            w = wdq.size() > 0 ? wdq.pop_front() : DW'($urandom);
            push_bits(w, DW);
            model[(a + k) % DEPTH] = w;
            exq.push_back({4'((a + k) % DEPTH), w});
        end
        frame(8 + n * DW, half);
        chk("wr_count", 64'(wq.size()), 64'(exq.size()));
        for (int k = 0; k < exq.size(); k++)
            chk("wr_event", 64'(k < wq.size() ? wq[k] : 'x), 64'(exq[k]));
        chk("wr_frame_done", 64'(fd_cnt - f0), 64'd1);
    endtask

    task automatic do_read(input int a, input int n, input int half);
        logic [7:0]    z;
        logic [DW-1:0] w;
        int            f0;
        push_bits(DW'({1'b0, 3'($urandom), 4'(a)}), 8);
        wq.delete();
        f0 = fd_cnt;
        frame(8 + n * DW, half);
        z = '0;
        for (int j = 0; j < 8; j++)
            z = {z[6:0], rxq[j]};
        chk("rd_cmd_miso", 64'(z), 64'd0);
        for (int k = 0; k < n; k++) begin
            w = '0;
            for (int j = 0; j < DW; j++)
                w = {w[DW-2:0], rxq[8 + k * DW + j]};
            chk("rd_word", 64'(w), 64'(model[(a + k) % DEPTH]));
        end
        chk("rd_no_write", 64'(wq.size()), 64'd0);
        chk("rd_frame_done", 64'(fd_cnt - f0), 64'd1);
    endtask

    task automatic do_partial(input int a, input int nbits);
        int f0;
        push_bits(DW'({1'b1, 3'b000, 4'(a)}), 8);
        wq.delete();
        f0 = fd_cnt;
        frame(8 + nbits, 3);
        chk("partial_no_write", 64'(wq.size()), 64'd0);
        chk("partial_frame_done", 64'(fd_cnt - f0), 64'd1);
    endtask

    initial begin
        logic [DW-1:0] w;
        int            f0;
        int            bad;
        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_miso", 64'(bus.miso), 64'd0);
        chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_frame_done", 64'(bus.frame_done), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            model[i] = '0;
        repeat (6) @(negedge clk);
        chk("idle_no_frame_done", 64'(fd_cnt), 64'd0);

        wdq.push_back(32'hDEADBEEF);
        do_write(3, 1, 3);
        do_read(3, 1, 3);

        wdq.push_back(32'h11111111);
        wdq.push_back(32'h22222222);
        do_write(15, 2, 3);
        do_read(15, 2, 3);

        do_partial(5, 20);
        do_read(5, 1, 3);

        // reset lands mid-way through the second word of a burst to address 2
        wq.delete();
        w = DW'($urandom);
        push_bits(DW'(8'h82), 8);
        push_bits(w, DW);
        fork
            frame(8 + DW + 20, 3);
            begin
                repeat (4 + (8 + DW + 10) * 6) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("midrst_miso", 64'(bus.miso), 64'd0);
            end
        join
        for (int i = 0; i < DEPTH; i++)
            model[i] = '0;
        chk("midrst_wr_count", 64'(wq.size()), 64'd1);
        chk("midrst_first_word", 64'(wq.size() > 0 ? wq[0] : 'x), 64'({4'd2, w}));
        do_read(0, 16, 3);
        wdq.push_back(32'hA5A5A5A5);
        do_write(2, 1, 3);
        do_read(2, 1, 3);

        // sclk and mosi active with cs held high must be invisible
        f0 = fd_cnt;
        bad = 0;
        wq.delete();
        bus.cs = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.mosi = 1'($urandom);
            repeat (2) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (2) @(negedge clk);
            if (bus.miso !== 1'b0)
                bad++;
            bus.sclk = 1'b0;
        end
        chk("cs_high_miso", 64'(bad), 64'd0);
        chk("cs_high_no_write", 64'(wq.size()), 64'd0);
        chk("cs_high_no_frame_done", 64'(fd_cnt - f0), 64'd0);

        do_write(14, 4, 2);
        do_read(14, 4, 2);

        do_read(7, 0, 3);
        do_write(9, 0, 3);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 1) == 1)
                do_write(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(2, 4)));
            else
                do_read(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(2, 4)));
        end
        do_read(0, 16, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_slave_regfile.md
Name: spi_slave_regfile

Overview:
SPI mode-0 slave endpoint with a local register file. It replaces the bare shift-register slave on each chip-select of the AHB-to-SPI bridge output. It decodes a command byte, then performs single or auto-incrementing burst reads and writes of DATA_W-bit words. SCLK, CS and MOSI are oversampled on the local SPI-domain clock. Every completed write is reported to local logic as a one-cycle strobe.

Parameters:
ADDR_W, 4, register address width; DEPTH = 2**ADDR_W words; legal range 1..7.
DATA_W, 32, register word width in bits; shifted MSB-first.

Ports:
clk  input  1  SPI-domain system clock (clk_spi at top level); must be >= 4x sclk frequency.
rst  input  1  synchronous, active-high reset.
sclk  input  1  SPI clock from master; idle low (CPOL=0, CPHA=0).
cs  input  1  active-low chip select.
mosi  input  1  master-out data.
miso  output  1  slave-out data; 0 whenever cs is high.
wr_valid  output  1  one-cycle pulse when a word is committed to the register file.
wr_addr  output  ADDR_W  address of the committed word; valid with wr_valid.
wr_data  output  DATA_W  committed word; valid with wr_valid.
frame_done  output  1  one-cycle pulse on synchronized cs rising edge.

Behaviour:
- Input conditioning:
  - sclk, cs and mosi each pass through a 2-FF synchronizer.
  - rise/fall = synchronized sclk edge detect, qualified by synchronized cs low.
  - Internal latency from a pin edge to action is 2-3 clk.
- Reset (synchronous): all registers = 0, state = IDLE, bit counter = 0, miso = 0, wr_valid = 0, wr_addr = 0, wr_data = 0, frame_done = 0.
- Command byte:
  - cmd[7] = 1 write, 0 read.
  - cmd[6:ADDR_W] ignored.
  - cmd[ADDR_W-1:0] = start address.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synchronized cs falling; clear bit counter and shift register.
  - CMD: shift mosi in on each rise. On the 8th rise, latch rw and address, then go to DATA with counter cleared.
  - DATA write: shift mosi on each rise. On the DATA_W-th rise:
    - regs[addr] <= word.
    - Pulse wr_valid with wr_addr/wr_data for 1 clk.
    - addr <= addr+1 (mod DEPTH).
    - Clear counter and stay in DATA.
  - DATA read:
    - On entry, load the out-shifter with regs[addr].
    - Drive miso = shifter MSB, updated on each fall: the first fall after the 8th command rise presents data bit DATA_W-1.
    - Shift on each subsequent fall.
    - After the DATA_W-th rise, increment addr (mod DEPTH) and reload the shifter from the new address before the next fall.
  - Any state -> IDLE on synchronized cs rising; frame_done pulses 1 clk.
- miso:
  - 0 in IDLE, in CMD, and whenever synchronized cs is high.
  - Registered output; no combinational path from pins.
- Boundary conditions:
  - cs deasserted mid-command: frame discarded; no register change.
  - cs deasserted mid-word: partial write word discarded; earlier complete words stay committed.
  - Burst write and read wrap from DEPTH-1 to 0.
  - Read of an address written earlier in the same burst returns the new value, since the reload happens after the commit.
  - rise and cs-rising in the same clk: cs-rising wins; the bit is ignored.
  - Reset mid-frame: immediate return to IDLE and registers cleared. The rest of the frame is ignored until cs goes high and then low again; cs must be seen high before a new frame is accepted.
  - Frame with 0 data bits (command only): no effect except frame_done.

Test Plan:
- Write cmd 0x83 + 0xDEADBEEF -> single wr_valid with wr_addr=3, wr_data=0xDEADBEEF. Read cmd 0x03 -> miso shifts 0xDEADBEEF MSB-first; frame_done pulses once per frame.
- Burst write cmd 0x8F + 0x11111111, 0x22222222 -> regs[15]=0x11111111, regs[0]=0x22222222 (wrap). Read cmd 0x0F for 64 bits -> same two words.
- Write cmd 0x85, cs raised after 20 data bits -> no wr_valid. Subsequent read of addr 5 returns 0x00000000.
- rst pulsed mid-burst-write after the first word to addr 2 -> all regs read 0, miso=0. Next frame (cs high then low) with write 0x82 + 0xA5A5A5A5 succeeds.
- cs high with sclk toggling and mosi random -> miso stays 0, no wr_valid, no frame_done.
- sclk at exactly clk/4 with full-rate burst reads of 4 words from addr 14 -> bit-exact data order 14, 15, 0, 1; no skipped or duplicated bits.
